id_ex_stage: RTL and testbench

Decode-to-execute boundary of the five-stage RV32I pipeline. It registers the decoded instruction into the ID/EX pipeline register: the control bits from `Control_unit`, register-file read data, immediate, PC and register indices. It contains the load-use hazard detector, which stalls PC and IF/ID and inserts a bubble. On a taken-branch flush it squashes the decoding instruction. Its outputs feed the EX stage, the ALU control and the forwarding unit.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/hazard_detect_unit.sv | 46 ++++
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALUOp encodings, instruction field
// positions and the ID/EX control-bit bundle.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_LDST = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_RI   = 2'b10;

  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 7;
  localparam int RD_LSB   = 7;
  localparam int F3_LSB   = 12;
  localparam int RS1_LSB  = 15;
  localparam int RS2_LSB  = 20;
  localparam int F7B5_BIT = 30;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detector: flags an ID instruction that reads the rd of a
// load currently sitting in EX.
module hazard_detect_unit
  import riscv_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [31:0]       id_instr,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_valid,
  output logic              hazard
);

  logic [OPC_W-1:0]  w_opcode;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic              w_uses_rs1;
  logic              w_uses_rs2;
  logic              w_unused;

  assign w_opcode = id_instr[OPC_LSB +: OPC_W];
  assign w_rs1    = id_instr[RS1_LSB +: REG_AW];
  assign w_rs2    = id_instr[RS2_LSB +: REG_AW];
  assign w_unused = &{1'b0, id_instr[31:25], id_instr[14:7]};

  always_comb begin
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_I, OP_LOAD: w_uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  // x0 is never a real producer, so a load into x0 cannot stall.
  assign hazard = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                  ((w_uses_rs1 && (ex_rd == w_rs1)) ||
                   (w_uses_rs2 && (ex_rd == w_rs2)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and taken-branch squash.
// Stall outputs are combinational from the ID inputs and current EX state.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              flush,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ex_valid,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_funct
);

  ctrl_t             w_id_ctrl;
  ctrl_t             r_ctrl;
  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [3:0]        r_funct;
  logic              w_hazard;
  logic              w_stall;
  logic              w_bubble;
  logic              w_unused;

  hazard_detect_unit #(.REG_AW(REG_AW)) u_hdu (
    .id_instr    (id_instr),
    .id_valid    (id_valid),
    .ex_rd       (r_rd),
    .ex_mem_read (r_ctrl.mem_read),
    .ex_valid    (r_valid),
    .hazard      (w_hazard)
  );

  // A flush overrides the stall so the PC is free to redirect.
  assign w_stall    = w_hazard && !flush;
  assign pc_write   = reset || !w_stall;
  assign ifid_write = reset || !w_stall;
  assign w_bubble   = reset || flush || w_hazard;
  assign w_unused   = &{1'b0, id_instr[31], id_instr[29:25], id_instr[6:0]};

  always_comb begin
    w_id_ctrl = '0;
    if (id_valid) begin
      w_id_ctrl.alu_op     = id_alu_op;
      w_id_ctrl.alu_src    = id_alu_src;
      w_id_ctrl.branch     = id_branch;
      w_id_ctrl.mem_read   = id_mem_read;
      w_id_ctrl.mem_write  = id_mem_write;
      w_id_ctrl.reg_write  = id_reg_write;
      w_id_ctrl.mem_to_reg = id_mem_to_reg;
    end
  end

  // ID -> EX register boundary
  always_ff @(posedge clk) begin
    if (w_bubble) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct    <= '0;
    end else begin
      r_valid    <= id_valid;
      r_ctrl     <= w_id_ctrl;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_instr[RS1_LSB +: REG_AW];
      r_rs2      <= id_instr[RS2_LSB +: REG_AW];
      r_rd       <= id_instr[RD_LSB +: REG_AW];
      r_funct    <= {id_instr[F7B5_BIT], id_instr[F3_LSB +: 3]};
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_branch     = r_ctrl.branch;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_pc         = r_pc;
  assign ex_rs1_data   = r_rs1_data;
  assign ex_rs2_data   = r_rs2_data;
  assign ex_imm        = r_imm;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_funct      = r_funct;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed test-plan steps followed by random traffic,
// all compared against an instruction-level reference model.
module tb_id_ex_stage;

  localparam logic [31:0] LW5   = 32'h00012283;
  localparam logic [31:0] ADD6  = 32'h00728333;
  localparam logic [31:0] LW0   = 32'h00012003;
  localparam logic [31:0] ADDX0 = 32'h00700333;
  localparam logic [31:0] ADDI8 = 32'h00148413;
  localparam logic [31:0] SUB6  = 32'h40728333;
  // {alu_op, alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg}
  localparam logic [7:0]  CT_LW = 8'b00_1_0_1_0_1_1;
  localparam logic [7:0]  CT_R  = 8'b10_0_0_0_0_1_0;
  localparam logic [7:0]  CT_I  = 8'b10_1_0_0_0_1_0;

  logic        clk = 1'b0;
  logic        reset, id_valid, flush;
  logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_branch, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic        pc_write, ifid_write, ex_valid;
  logic [1:0]  ex_alu_op;
  logic        ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: the instruction record expected to sit in EX.
  logic        m_valid = 1'b0;
  logic [7:0]  m_ctrl = '0;
  logic [31:0] m_pc = '0, m_d1 = '0, m_d2 = '0, m_imm = '0;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic [3:0]  m_funct = '0;

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .flush(flush), .pc_write(pc_write), .ifid_write(ifid_write),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct(ex_funct)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic vld, input logic [7:0] ct,
                       input logic fl);
    id_instr = instr;
    id_valid = vld;
    {id_alu_op, id_alu_src, id_branch, id_mem_read, id_mem_write, id_reg_write,
     id_mem_to_reg} = ct;
    flush       = fl;
    id_pc       = $urandom;
    id_rs1_data = $urandom;
    id_rs2_data = $urandom;
    id_imm      = $urandom;
  endtask

  // Does the instruction in ID read the register the EX load is writing?
  function automatic logic model_hazard();
    logic [6:0] op;
    logic       u1, u2;
    op = id_instr[6:0];
    u1 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011) ||
         (op == 7'b0010011) || (op == 7'b0000011);
    u2 = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
    return m_valid && m_ctrl[3] && (m_rd != 5'd0) && id_valid &&
           ((u1 && (m_rd == id_instr[19:15])) || (u2 && (m_rd == id_instr[24:20])));
  endfunction

  // Inputs are applied just after a negedge; checks stall, clocks, checks EX.
  task automatic step();
    logic hz, exp_wr;
    #1;
    hz     = model_hazard();
    exp_wr = reset ? 1'b1 : !(hz && !flush);
    chk("pc_write", 128'(pc_write), 128'(exp_wr));
    chk("ifid_write", 128'(ifid_write), 128'(exp_wr));
    @(posedge clk);
    if (reset || flush || hz) begin
      m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_funct = '0;
    end else begin
      m_valid = id_valid;
      m_ctrl  = id_valid ? {id_alu_op, id_alu_src, id_branch, id_mem_read, id_mem_write,
                            id_reg_write, id_mem_to_reg} : 8'h00;
      m_pc = id_pc; m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm;
      m_rs1 = id_instr[19:15]; m_rs2 = id_instr[24:20]; m_rd = id_instr[11:7];
      m_funct = {id_instr[30], id_instr[14:12]};
    end
    #1;
    chk("ex_valid", 128'(ex_valid), 128'(m_valid));
    chk("ex_ctrl", 128'({ex_alu_op, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write,
                          ex_reg_write, ex_mem_to_reg}), 128'(m_ctrl));
    chk("ex_data", {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm}, {m_pc, m_d1, m_d2, m_imm});
    chk("ex_idx", 128'({ex_rs1, ex_rs2, ex_rd, ex_funct}), 128'({m_rs1, m_rs2, m_rd, m_funct}));
    @(negedge clk);
  endtask

  initial begin
    logic [6:0]  ops [7];
    logic [31:0] ri;
    logic [7:0]  rc;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b1101111};
    reset = 1'b1;
    drive(32'h0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_ex_valid", 128'(ex_valid), 128'(0));
    chk("rst_ex_all", {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm}, 128'(0));
    chk("rst_pc_write", 128'(pc_write), 128'(1));
    step();

    // Load-use: lw x5 then add x6,x5,x7 stalls one cycle
    drive(LW5, 1'b1, CT_LW, 1'b0);
    step();
    drive(ADD6, 1'b1, CT_R, 1'b0);
    #1;
    chk("lu_pc_write", 128'(pc_write), 128'(0));
    chk("lu_ifid_write", 128'(ifid_write), 128'(0));
    step();
    chk("lu_bubble", 128'(ex_valid), 128'(0));
    step();
    chk("lu_rd", 128'(ex_rd), 128'(6));
    chk("lu_reg_write", 128'(ex_reg_write), 128'(1));

    // Load into x0 never stalls
    drive(LW0, 1'b1, CT_LW, 1'b0);
    step();
    drive(ADDX0, 1'b1, CT_R, 1'b0);
    #1;
    chk("x0_pc_write", 128'(pc_write), 128'(1));
    step();
    chk("x0_valid", 128'(ex_valid), 128'(1));
    chk("x0_rs1", 128'(ex_rs1), 128'(0));

    // Independent consumer
    drive(LW5, 1'b1, CT_LW, 1'b0);
    step();
    drive(ADDI8, 1'b1, CT_I, 1'b0);
    #1;
    chk("indep_pc_write", 128'(pc_write), 128'(1));
    step();
    chk("indep_rd", 128'(ex_rd), 128'(8));

    // Hazard and flush together: flush wins, no stall
    drive(LW5, 1'b1, CT_LW, 1'b0);
    step();
    drive(ADD6, 1'b1, CT_R, 1'b1);
    #1;
    chk("hzfl_pc_write", 128'(pc_write), 128'(1));
    step();
    chk("hzfl_valid", 128'(ex_valid), 128'(0));
    chk("hzfl_reg_write", 128'(ex_reg_write), 128'(0));

    // sub with id_valid low, then high
    drive(SUB6, 1'b0, CT_R, 1'b0);
    step();
    chk("sub_inv_valid", 128'(ex_valid), 128'(0));
    chk("sub_inv_alu_op", 128'(ex_alu_op), 128'(0));
    drive(SUB6, 1'b1, CT_R, 1'b0);
    step();
    chk("sub_funct", 128'(ex_funct), 128'(4'b1000));
    chk("sub_alu_op", 128'(ex_alu_op), 128'(2'b10));

    // Reset in the middle of a stall
    drive(LW5, 1'b1, CT_LW, 1'b0);
    step();
    drive(ADD6, 1'b1, CT_R, 1'b0);
    reset = 1'b1;
    #1;
    chk("rststall_pc_write", 128'(pc_write), 128'(1));
    step();
    reset = 1'b0;
    chk("rststall_valid", 128'(ex_valid), 128'(0));

    // Random traffic with a small register pool so hazards are frequent
    for (int i = 0; i < 600; i++) begin
      ri = $urandom;
      ri[6:0]   = ops[$urandom_range(0, 6)];
      ri[11:7]  = 5'($urandom_range(0, 3));
      ri[19:15] = 5'($urandom_range(0, 3));
      ri[24:20] = 5'($urandom_range(0, 3));
      rc = 8'($urandom);
      rc[3] = (ri[6:0] == 7'b0000011) || ($urandom_range(0, 9) == 0);
      drive(ri, ($urandom_range(0, 99) < 85), rc, ($urandom_range(0, 99) < 10));
      reset = ($urandom_range(0, 99) < 3);
      step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
